// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch queue bus: ROM fetch port, redirect request and decode handshake
interface if_fetch_queue_if;
  logic [31:0] inst_a;
  logic [31:0] inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] perf_fetch;
  logic [31:0] perf_bubble;

  modport master (
    output inst_a, id_valid, id_inst, id_pc, id_pc4, perf_fetch, perf_bubble,
    input  inst, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  inst_a, id_valid, id_inst, id_pc, id_pc4, perf_fetch, perf_bubble,
    output inst, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch PC plus QDEPTH-entry queue feeding decode
// Optional IF_PERF_CNT_EN adds saturating push and empty-cycle counters.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_queue_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [31:0]   r_pc;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_pc   [QDEPTH];
  logic [31:0]   r_q_inst [QDEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.id_ready & ~bus.redirect;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign w_push  = ~bus.redirect & ((r_count < FULL) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.redirect) begin
      r_pc    <= bus.redirect_pc & ~32'h3;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 32'd4;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wptr]   <= r_pc;
      r_q_inst[r_wptr] <= bus.inst;
    end
  end

  assign bus.inst_a   = r_pc;
  assign bus.id_valid = w_valid;
  assign bus.id_inst  = r_q_inst[r_rptr];
  assign bus.id_pc    = r_q_pc[r_rptr];
  assign bus.id_pc4   = r_q_pc[r_rptr] + 32'd4;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch  <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_push && (r_perf_fetch != 32'hFFFF_FFFF)) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (!w_valid && (r_perf_bubble != 32'hFFFF_FFFF)) begin
        r_perf_bubble <= r_perf_bubble + 32'd1;
      end
    end
  end

  assign bus.perf_fetch  = r_perf_fetch;
  assign bus.perf_bubble = r_perf_bubble;
`else
  assign bus.perf_fetch  = 32'h0;
  assign bus.perf_bubble = 32'h0;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue against a queue-based model
module tb_if_fetch_queue;
  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rom_key = 32'h0;

  if_fetch_queue_if bus();
  assign bus.inst = bus.inst_a ^ rom_key;

  if_fetch_queue #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  longint      m_fetch;
  longint      m_bub;

  function automatic logic [31:0] pf_exp(longint v);
`ifdef IF_PERF_CNT_EN
    if (v > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = RPC;
    q_pc.delete();
    q_inst.delete();
    m_fetch = 0;
    m_bub = 0;
  endtask

  // Advance one clock and apply the behavioural rules to the model.
  task automatic tick();
    int n;
    bit pop;
    bit push;
    @(posedge clk);
    n = q_pc.size();
    if (n == 0) m_bub++;
    if (bus.redirect) begin
      q_pc.delete();
      q_inst.delete();
      m_pc = bus.redirect_pc & ~32'h3;
    end else begin
      pop  = (n > 0) && bus.id_ready;
      push = (n < QD) || pop;
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (push) begin
        q_pc.push_back(m_pc);
        q_inst.push_back(m_pc ^ rom_key);
        m_pc = m_pc + 32'd4;
        m_fetch++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    bus.redirect = 1'b0;
    bus.id_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++; if (bus.inst_a !== RPC) begin bad++; $display("FAIL rst_inst_a got=%h exp=%h", bus.inst_a, RPC); end
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.id_valid); end
    total++; if (bus.perf_fetch !== 32'h0 || bus.perf_bubble !== 32'h0) begin bad++; $display("FAIL rst_perf got=%h/%h exp=0/0", bus.perf_fetch, bus.perf_bubble); end
    @(posedge clk); #1;
    total++; if (bus.id_valid !== 1'b0 || bus.inst_a !== RPC) begin bad++; $display("FAIL rst_hold got=%b/%h exp=0/%h", bus.id_valid, bus.inst_a, RPC); end
    rst = 1'b0;
    tick();
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== RPC) begin bad++; $display("FAIL rst_first_push got=%b/%h exp=1/%h", bus.id_valid, bus.id_pc, RPC); end
  endtask

  task automatic test_sequential();
    rom_key = 32'h0;
    do_reset();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== RPC + 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%b/%h exp=1/%h", i, bus.id_valid, bus.id_pc, RPC + 32'(4 * i)); end
      total++; if (bus.id_pc4 !== bus.id_pc + 32'd4 || bus.id_inst !== bus.id_pc) begin bad++; $display("FAIL seq_fields%0d got=%h/%h exp=%h/%h", i, bus.id_pc4, bus.id_inst, RPC + 32'(4 * i + 4), RPC + 32'(4 * i)); end
    end
  endtask

  task automatic test_stall();
    rom_key = 32'h0;
    do_reset();
    repeat (6) tick();
    total++; if (bus.inst_a !== 32'h8) begin bad++; $display("FAIL stall_inst_a got=%h exp=00000008", bus.inst_a); end
    total++; if (q_pc.size() != QD || bus.id_valid !== 1'b1) begin bad++; $display("FAIL stall_full got=%b exp=1", bus.id_valid); end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.id_pc !== 32'(4 * i) || bus.id_inst !== 32'(4 * i)) begin bad++; $display("FAIL stall_order%0d got=%h/%h exp=%h", i, bus.id_pc, bus.id_inst, 32'(4 * i)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    rom_key = 32'h0;
    do_reset();
    repeat (3) tick();
    rom_key = 32'h5A5A_0000;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    total++; if (bus.id_valid !== 1'b0 || bus.inst_a !== 32'h100) begin bad++; $display("FAIL redir_flush got=%b/%h exp=0/00000100", bus.id_valid, bus.inst_a); end
    bus.id_ready = 1'b1;
    tick();
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_inst !== (32'h100 ^ rom_key)) begin bad++; $display("FAIL redir_target got=%b/%h/%h exp=1/00000100/%h", bus.id_valid, bus.id_pc, bus.id_inst, 32'h100 ^ rom_key); end
    tick();
    total++; if (bus.id_pc !== 32'h104) begin bad++; $display("FAIL redir_next got=%h exp=00000104", bus.id_pc); end
  endtask

  task automatic test_wrap();
    bus.id_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    tick();
    total++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/00000000", bus.id_pc, bus.id_pc4); end
    tick();
    total++; if (bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1) begin bad++; $display("FAIL wrap_zero got=%b/%h exp=1/00000000", bus.id_valid, bus.id_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) tick();
    total++; if (bus.id_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", bus.id_valid); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (bus.id_valid !== 1'b0 || bus.inst_a !== RPC) begin bad++; $display("FAIL arst_drop got=%b/%h exp=0/%h", bus.id_valid, bus.inst_a, RPC); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== RPC) begin bad++; $display("FAIL arst_restart got=%b/%h exp=1/%h", bus.id_valid, bus.id_pc, RPC); end
  endtask

  task automatic test_random();
    rom_key = $urandom;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus.id_ready = ($urandom_range(0, 3) != 0);
      bus.redirect = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick();
      total++; if (bus.inst_a !== m_pc) begin bad++; $display("FAIL rnd_inst_a cyc=%0d got=%h exp=%h", i, bus.inst_a, m_pc); end
      total++; if (bus.id_valid !== (q_pc.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.id_valid, q_pc.size() != 0); end
      if (q_pc.size() != 0) begin
        total++; if (bus.id_pc !== q_pc[0] || bus.id_inst !== q_inst[0] || bus.id_pc4 !== q_pc[0] + 32'd4) begin bad++; $display("FAIL rnd_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", i, bus.id_pc, bus.id_inst, bus.id_pc4, q_pc[0], q_inst[0], q_pc[0] + 32'd4); end
      end
      total++; if (bus.perf_fetch !== pf_exp(m_fetch) || bus.perf_bubble !== pf_exp(m_bub)) begin bad++; $display("FAIL rnd_perf cyc=%0d got=%h/%h exp=%h/%h", i, bus.perf_fetch, bus.perf_bubble, pf_exp(m_fetch), pf_exp(m_bub)); end
    end
    bus.redirect = 1'b0;
  endtask

  task automatic test_perf();
    rom_key = 32'h0;
    do_reset();
    bus.id_ready = 1'b1;
    repeat (10) tick();
    bus.redirect = 1'b1;
    repeat (3) begin
      bus.redirect_pc = $urandom;
      tick();
    end
    bus.redirect = 1'b0;
    total++; if (bus.perf_fetch !== pf_exp(m_fetch)) begin bad++; $display("FAIL perf_fetch got=%h exp=%h", bus.perf_fetch, pf_exp(m_fetch)); end
    total++; if (bus.perf_bubble !== pf_exp(m_bub)) begin bad++; $display("FAIL perf_bubble got=%h exp=%h", bus.perf_bubble, pf_exp(m_bub)); end
  endtask

  initial begin
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready = 1'b0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
